// File: rtl/color_config_master.sv
// Config-bus initiator: buffers register writes in a FIFO and issues them as
// active-low C_Valid pulses, with ack timeout. Define COLOR_CFG_RETRY_EN to re-issue on timeout.
module color_config_master #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 15,
  parameter int MAX_RETRY    = 2
) (
  input  logic                    Clk,
  input  logic                    rst_n,
  input  logic                    Req_Valid,
  input  logic [C_ADDR_WIDTH-1:0] Req_Addr,
  input  logic [C_DATA_WIDTH-1:0] Req_Data,
  output logic                    Req_Rdy,
  output logic [C_ADDR_WIDTH-1:0] C_Addr,
  output logic [C_DATA_WIDTH-1:0] C_Data,
  output logic                    C_Valid,
  input  logic                    C_Rdy,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err,
  output logic [C_ADDR_WIDTH-1:0] Err_Addr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = C_ADDR_WIDTH + C_DATA_WIDTH;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (TIMEOUT < 2) || (MAX_RETRY < 0)) begin : g_bad_param
    $error("color_config_master: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [EW-1:0]           mem_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [C_ADDR_WIDTH-1:0] c_addr_q, c_addr_d, err_addr_q, err_addr_d;
  logic [C_DATA_WIDTH-1:0] c_data_q, c_data_d;
  logic                    c_valid_q, c_valid_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    push, pop;
`ifdef COLOR_CFG_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0]           retry_q, retry_d;
`endif

  assign Req_Rdy  = (count_q != CW'(FIFO_DEPTH));
  assign Busy     = (count_q != '0) || (state_q != IDLE);
  assign C_Addr   = c_addr_q;
  assign C_Data   = c_data_q;
  assign C_Valid  = c_valid_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign Err_Addr = err_addr_q;

  always_comb begin
    push     = Req_Valid && Req_Rdy;
    pop      = (state_q == IDLE) && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {Req_Addr, Req_Data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d    = state_q;
    c_addr_d   = c_addr_q;
    c_data_d   = c_data_q;
    timer_d    = timer_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
`ifdef COLOR_CFG_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          {c_addr_d, c_data_d} = mem_q[rd_ptr_q];
          state_d              = ISSUE;
`ifdef COLOR_CFG_RETRY_EN
          retry_d              = '0;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        // Acks seen in IDLE/ISSUE are stale and never reach this branch.
        if (!C_Rdy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
`ifdef COLOR_CFG_RETRY_EN
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ISSUE;
          end else begin
            err_d      = 1'b1;
            err_addr_d = c_addr_q;
            state_d    = IDLE;
          end
`else
          err_d      = 1'b1;
          err_addr_d = c_addr_q;
          state_d    = IDLE;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // C_Valid is a registered copy of "next cycle is ISSUE".
    c_valid_d = (state_d != ISSUE);
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      c_valid_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
`ifdef COLOR_CFG_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      c_addr_q   <= c_addr_d;
      c_data_q   <= c_data_d;
      c_valid_q  <= c_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`ifdef COLOR_CFG_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_color_config_master.sv
// Bench for color_config_master: table of single writes plus sequences for
// FIFO full, timeout, stale ack and mid-transaction reset.
module tb_color_config_master;

  localparam int AW = 4, DW = 16, DEPTH = 4, TO = 15, MR = 2, W = AW + DW;
`ifdef COLOR_CFG_RETRY_EN
  localparam int TO_PULSES = MR + 1;
`else
  localparam int TO_PULSES = 1;
`endif

  logic          Clk = 1'b0, rst_n = 1'b0, Req_Valid = 1'b0, C_Rdy = 1'b1;
  logic [AW-1:0] Req_Addr = '0;
  logic [DW-1:0] Req_Data = '0;
  logic          Req_Rdy, C_Valid, Busy, Done, Err;
  logic [AW-1:0] C_Addr, Err_Addr;
  logic [DW-1:0] C_Data;

  color_config_master #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                        .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .Clk(Clk), .rst_n(rst_n), .Req_Valid(Req_Valid), .Req_Addr(Req_Addr),
    .Req_Data(Req_Data), .Req_Rdy(Req_Rdy), .C_Addr(C_Addr), .C_Data(C_Data),
    .C_Valid(C_Valid), .C_Rdy(C_Rdy), .Busy(Busy), .Done(Done), .Err(Err),
    .Err_Addr(Err_Addr)
  );

  // clock / reset / cycle counter
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [W-1:0] exp_q[$];
  int pulse_cyc_q[$], err_cyc_q[$];
  int pulse_cnt = 0, done_cnt = 0, err_cnt = 0, last_done_cyc = 0;
  int resp_mode = 0;  // 0: never ack, 1: registered ack, 2: manual
  logic prev_cv = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // responder: acks in the cycle after it sees a C_Valid pulse
  always @(posedge Clk) begin
    logic cv;
    cv = C_Valid;
    #1;
    case (resp_mode)
      0: C_Rdy = 1'b1;
      1: C_Rdy = cv;
      default: ;
    endcase
  end

  // scoreboard monitor
  always @(negedge Clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (!C_Valid) begin
        pulse_cnt++;
        pulse_cyc_q.push_back(cyc);
        check("pulse_width", prev_cv, 1'b1);
        if (exp_q.size() == 0) fail("pulse_unexpected");
        else begin
          e = exp_q[0];
          check("c_addr", C_Addr, e[W-1:DW]);
          check("c_data", C_Data, e[DW-1:0]);
        end
      end
      if (Done && Err) fail("done_and_err");
      if (Done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) fail("done_unexpected");
        else void'(exp_q.pop_front());
      end
      if (Err) begin
        err_cnt++;
        err_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) fail("err_unexpected");
        else begin
          e = exp_q.pop_front();
          check("err_addr", Err_Addr, e[W-1:DW]);
        end
      end
    end
    prev_cv = C_Valid;
  end

  // driver: one push attempt; pc = cycle index following the push edge
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output bit acc, output int pc);
    @(negedge Clk);
    Req_Valid = 1'b1;
    Req_Addr  = a;
    Req_Data  = d;
    acc       = Req_Rdy;
    pc        = cyc + 1;
    @(posedge Clk);
    if (acc) exp_q.push_back({a, d});
    #1 Req_Valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge Clk);
    while (Busy && n < max_cyc) begin
      @(negedge Clk);
      n++;
    end
    if (Busy) fail("idle_timeout");
    @(negedge Clk);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            ack;
    int            exp_done;
    int            exp_err;
    int            exp_pulses;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit acc;
    int pc, p0, d0, e0, pc0;
    bit exp_acc[6];

    vt[0] = '{4'h1, 16'h0002, 1'b1, 1, 0, 1};
    vt[1] = '{4'hF, 16'hFFFF, 1'b1, 1, 0, 1};
    vt[2] = '{4'h0, 16'h0000, 1'b1, 1, 0, 1};
    vt[3] = '{4'h7, 16'hA5A5, 1'b1, 1, 0, 1};
    vt[4] = '{4'h3, 16'h1234, 1'b0, 0, 1, TO_PULSES};
    vt[5] = '{AW'($urandom_range(0, 15)), DW'($urandom_range(0, 65535)), 1'b1, 1, 0, 1};

    // reset state
    repeat (3) @(negedge Clk);
    check("rst_c_valid", C_Valid, 1'b1);
    check("rst_c_addr", C_Addr, 0);
    check("rst_c_data", C_Data, 0);
    check("rst_done", Done, 1'b0);
    check("rst_err", Err, 1'b0);
    check("rst_err_addr", Err_Addr, 0);
    check("rst_busy", Busy, 1'b0);
    check("rst_req_rdy", Req_Rdy, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // table of single writes
    for (int i = 0; i < 6; i++) begin
      resp_mode = vt[i].ack ? 1 : 0;
      p0 = pulse_cnt; d0 = done_cnt; e0 = err_cnt;
      pulse_cyc_q.delete();
      push(vt[i].addr, vt[i].data, acc, pc);
      check("tbl_accept", acc, 1'b1);
      wait_idle(300);
      check("tbl_done", done_cnt - d0, vt[i].exp_done);
      check("tbl_err", err_cnt - e0, vt[i].exp_err);
      check("tbl_pulses", pulse_cnt - p0, vt[i].exp_pulses);
      if (vt[i].exp_err != 0) check("tbl_err_addr_hold", Err_Addr, vt[i].addr);
      if (i == 0 && pulse_cyc_q.size() > 0) begin
        check("lat_pulse", pulse_cyc_q[0], pc + 1);
        check("lat_done", last_done_cyc, pc + 3);
      end
    end

    // FIFO full: responder stalled, six back-to-back pushes
    resp_mode = 0;
    d0 = done_cnt; e0 = err_cnt;
    exp_acc = '{1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      push(AW'(8 + i), DW'(16'h0100 * (i + 1) + i), acc, pc);
      check("full_accept", acc, exp_acc[i]);
      if (i == 4) check("full_req_rdy", Req_Rdy, 1'b0);
    end
    @(negedge Clk);
    resp_mode = 2;
    C_Rdy = 1'b0;
    wait_idle(300);
    C_Rdy = 1'b1;
    resp_mode = 0;
    check("full_done", done_cnt - d0, 5);
    check("full_err", err_cnt - e0, 0);
    check("full_drained", exp_q.size(), 0);

    // timeout with a second entry queued behind it
    p0 = pulse_cnt; e0 = err_cnt;
    pulse_cyc_q.delete();
    err_cyc_q.delete();
    push(4'h5, 16'hBEEF, acc, pc0);
    push(4'h6, 16'h1111, acc, pc);
    wait_idle(400);
    check("to_pulses", pulse_cnt - p0, 2 * TO_PULSES);
    check("to_errs", err_cnt - e0, 2);
    check("to_err_addr", Err_Addr, 4'h6);
    if (pulse_cyc_q.size() == 2 * TO_PULSES && err_cyc_q.size() == 2) begin
      check("to_first_pulse", pulse_cyc_q[0], pc0 + 1);
      for (int k = 1; k < TO_PULSES; k++)
        check("to_retry_gap", pulse_cyc_q[k] - pulse_cyc_q[k-1], TO + 1);
      check("to_err_time", err_cyc_q[0], pulse_cyc_q[TO_PULSES-1] + TO + 1);
      check("to_next_issue", pulse_cyc_q[TO_PULSES], err_cyc_q[0] + 1);
    end else fail("to_event_count");

    // ack present only during IDLE and ISSUE is ignored
    resp_mode = 2;
    C_Rdy = 1'b0;
    p0 = pulse_cnt; d0 = done_cnt; e0 = err_cnt;
    push(4'h9, 16'h0909, acc, pc);
    @(posedge Clk);
    @(posedge Clk);
    #1 C_Rdy = 1'b1;
    wait_idle(400);
    check("stale_done", done_cnt - d0, 0);
    check("stale_err", err_cnt - e0, 1);
    check("stale_pulses", pulse_cnt - p0, TO_PULSES);
    resp_mode = 0;

    // reset while in WAIT with two entries queued
    push(4'hA, 16'hAAAA, acc, pc);
    push(4'hB, 16'hBBBB, acc, pc);
    push(4'hC, 16'hCCCC, acc, pc);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_c_valid", C_Valid, 1'b1);
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_req_rdy", Req_Rdy, 1'b1);
    check("mid_rst_err_addr", Err_Addr, 0);
    exp_q.delete();
    p0 = pulse_cnt; d0 = done_cnt; e0 = err_cnt;
    @(negedge Clk);
    rst_n = 1'b1;
    repeat (40) @(negedge Clk);
    check("post_rst_pulses", pulse_cnt - p0, 0);
    check("post_rst_done", done_cnt - d0, 0);
    check("post_rst_err", err_cnt - e0, 0);
    check("post_rst_busy", Busy, 1'b0);

    // random acked burst
    resp_mode = 1;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      push(AW'($urandom_range(0, 15)), DW'($urandom_range(0, 65535)), acc, pc);
      check("rnd_accept", acc, 1'b1);
    end
    wait_idle(300);
    check("rnd_done", done_cnt - d0, 4);
    check("rnd_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
